// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and elaboration helpers.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_CNT_W    = 10;
    localparam int unsigned VGA_COLOR_W  = 3;

    function automatic int unsigned vga_total(input int unsigned act, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    // True when a count of 'total' states fits in a w-bit counter.
    function automatic bit vga_fits(input int unsigned total, input int unsigned w);
        return 64'(total) <= (64'd1 << w);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register that realigns syncs/data-enable with renderer latency.
module vga_sync_delay #(
    parameter int unsigned           WIDTH     = 3,
    parameter int unsigned           DEPTH     = 2,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, nrst, en};
        assign q_o = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] sr_q [DEPTH];

        always_ff @(posedge clk) begin
            if (!nrst) begin
                for (int i = 0; i < DEPTH; i++) sr_q[i] <= RESET_VAL;
            end else if (en) begin
                sr_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
            end
        end

        assign q_o = sr_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: coordinates, strobes, pipeline-aligned syncs
// and blanked colour, all on the pixel clock.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned H_FP        = VGA_H_FP,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BP        = VGA_H_BP,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned V_FP        = VGA_V_FP,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BP        = VGA_V_BP,
    parameter bit          HSYNC_POL   = 1'b1,
    parameter bit          VSYNC_POL   = 1'b1,
    parameter int unsigned CNT_W       = VGA_CNT_W,
    parameter int unsigned COLOR_W     = VGA_COLOR_W,
    parameter int unsigned PIPE        = 2,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter int unsigned TICK_DIV    = 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               en,
    input  logic [COLOR_W-1:0] color_in,
    output logic [CNT_W-1:0]   x_pos,
    output logic [CNT_W-1:0]   y_pos,
    output logic               active,
    output logic               frame_start,
    output logic               line_start,
    output logic               game_tick,
    output logic               hsync,
    output logic               vsync,
    output logic               de_out,
    output logic [COLOR_W-1:0] color_out
);

    localparam int unsigned H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned FCNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0]  H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_TICK = CNT_W'(V_ACTIVE);
    localparam logic [FCNT_W-1:0] F_LAST = FCNT_W'(TICK_DIV - 1);

    if (!vga_fits(H_TOTAL, CNT_W)) begin : g_bad_h_total
        $error("H_TOTAL does not fit in CNT_W bits");
    end
    if (!vga_fits(V_TOTAL, CNT_W)) begin : g_bad_v_total
        $error("V_TOTAL does not fit in CNT_W bits");
    end
    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 1");
    end
    if (SCALE_SHIFT >= CNT_W) begin : g_bad_scale
        $error("SCALE_SHIFT must be smaller than CNT_W");
    end

    logic [CNT_W-1:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic               active_q, active_d;
    logic               frame_q, frame_d, line_q, line_d, tick_q, tick_d;
    logic               hsync_q, vsync_q, de_q;
    logic [COLOR_W-1:0] color_q;
    logic               hs_raw, vs_raw, hs_tap, vs_tap, de_tap;

    // Next position and the strobes that belong to it, so strobes line up with x_pos/y_pos.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        fcnt_d  = fcnt_q;
        tick_d  = 1'b0;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
        end else begin
            h_cnt_d = h_cnt_q + CNT_W'(1);
        end
        if ((h_cnt_d == '0) && (v_cnt_d == V_TICK)) begin
            tick_d = (fcnt_q == F_LAST);
            fcnt_d = tick_d ? '0 : fcnt_q + FCNT_W'(1);
        end
        active_d = (32'(h_cnt_d) < H_ACTIVE) && (32'(v_cnt_d) < V_ACTIVE);
        frame_d  = (h_cnt_d == '0) && (v_cnt_d == '0);
        line_d   = (h_cnt_d == '0) && (32'(v_cnt_d) < V_ACTIVE);
    end

    assign hs_raw = ((32'(h_cnt_q) >= HS_START) && (32'(h_cnt_q) < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    assign vs_raw = ((32'(v_cnt_q) >= VS_START) && (32'(v_cnt_q) < VS_END)) ? VSYNC_POL : ~VSYNC_POL;

    // PIPE stages here plus the output register below give the full PIPE+1 lag.
    vga_sync_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE),
        .RESET_VAL ({~HSYNC_POL, ~VSYNC_POL, 1'b0})
    ) u_sync_delay (
        .clk  (clk),
        .nrst (nrst),
        .en   (en),
        .d_i  ({hs_raw, vs_raw, active_q}),
        .q_o  ({hs_tap, vs_tap, de_tap})
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            h_cnt_q  <= H_LAST;
            v_cnt_q  <= V_LAST;
            fcnt_q   <= F_LAST;
            active_q <= 1'b0;
            frame_q  <= 1'b0;
            line_q   <= 1'b0;
            tick_q   <= 1'b0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            de_q     <= 1'b0;
            color_q  <= '0;
        end else if (en) begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            fcnt_q   <= fcnt_d;
            active_q <= active_d;
            frame_q  <= frame_d;
            line_q   <= line_d;
            tick_q   <= tick_d;
            hsync_q  <= hs_tap;
            vsync_q  <= vs_tap;
            de_q     <= de_tap;
            color_q  <= de_tap ? color_in : '0;
        end
    end

    assign x_pos       = h_cnt_q >> SCALE_SHIFT;
    assign y_pos       = v_cnt_q >> SCALE_SHIFT;
    assign active      = active_q;
    assign frame_start = frame_q;
    assign line_start  = line_q;
    assign game_tick   = tick_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de_out      = de_q;
    assign color_out   = color_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and output stage. It supersedes the fixed 640x480 counter/colour pair inside the VGA top level. It produces pixel coordinates for the renderer, realigns hsync/vsync/data-enable with a renderer of configurable pipeline latency, blanks colour outside the active area, and emits frame/line/game-tick strobes so game logic runs on the pixel clock domain instead of a separate game clock.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- HSYNC_POL / VSYNC_POL, 1 / 1, asserted level of each sync output
- CNT_W, 10, counter and coordinate width
- COLOR_W, 3, colour width
- PIPE, 2, renderer latency in cycles from x_pos/y_pos to color_in; 0 is legal
- SCALE_SHIFT, 0, coordinate downscale: x_pos = h_cnt >> SCALE_SHIFT
- TICK_DIV, 1, frames per game_tick

Ports:
- clk, in, 1, pixel clock (PLL output)
- nrst, in, 1, reset, synchronous, active-low
- en, in, 1, count enable; low freezes the whole block
- color_in, in, COLOR_W, renderer colour, PIPE cycles after its coordinates
- x_pos / y_pos, out, CNT_W, scaled current coordinates (undelayed)
- active, out, 1, current coordinate is visible (undelayed)
- frame_start / line_start / game_tick, out, 1, single-cycle strobes aligned to x_pos/y_pos
- hsync / vsync, out, 1, delayed syncs at the configured polarity
- de_out, out, 1, delayed data-enable
- color_out, out, COLOR_W, blanked colour aligned with hsync/vsync/de_out

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way. Elaboration fails if either total exceeds 2^CNT_W, if TICK_DIV < 1, or if SCALE_SHIFT >= CNT_W.
- h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps and itself wraps from V_TOTAL-1 to 0.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Raw hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Raw vsync is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for the whole line.
- x_pos/y_pos are always the shifted counters, including during blanking. The renderer gates its output on active.
- frame_start is high when h=0 and v=0.
- line_start is high when h=0 and v < V_ACTIVE.
- game_tick is high when h=0 and v=V_ACTIVE, but only on every TICK_DIV-th frame. A frame counter 0..TICK_DIV-1 advances at that point and ticks on value TICK_DIV-1.
- Raw hsync, vsync and active pass through a PIPE+1 stage delay. color_out is registered as (active delayed by PIPE ? color_in : 0).
- en low: counters, frame counter, delay line and all outputs hold their values. Strobes hold too, so a strobe held high by en-low is not a second event for consumers that also qualify with en.

## Timing
- Reset values: h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, so x_pos/y_pos read the shifted values of those counts (799/524 at defaults). The frame counter resets to TICK_DIV-1. active, de_out, color_out, frame_start, line_start and game_tick reset to 0. hsync/vsync reset to their inactive levels; the whole delay line is cleared to inactive.
- On the first enabled cycle after nrst rises, counters roll to 0,0 and frame_start=1, active=1, line_start=1. The first game_tick follows at v=V_ACTIVE of that frame.
- Strobe latency is 0 relative to x_pos/y_pos.
- hsync, vsync, de_out and color_out lag x_pos/y_pos by exactly PIPE+1 cycles.
- Asserting nrst mid-frame returns to the reset state on the next edge. No partial strobe or sync pulse leaks out; the delay line is flushed.
- Simultaneous h wrap and v wrap: frame_start and line_start both assert in the same cycle.

## Structure
- Package vga_pkg holds the default 640x480@60 timing localparams, a total-width function and the COLOR_W default.
- Sub-module vga_sync_delay: a parametric shift register (WIDTH, DEPTH, RESET_VAL, enable) used for {hsync, vsync, de}.

## Test plan
Small timing (H 8/2/2/2, V 4/1/1/1, PIPE=2) unless noted.
- Reset held, then released: outputs at reset values while nrst=0. First enabled cycle gives x=0, y=0, frame_start=1. Line period is 14 cycles, frame period 98 cycles.
- Sync placement: hsync asserted for h=10..11, delayed 3 cycles. vsync asserted for all of line 5. Repeat with HSYNC_POL=0 and VSYNC_POL=0 to confirm inverted levels.
- Alignment: color_in = low bits of the x_pos seen PIPE cycles earlier. color_out must equal the x of the same delayed pixel while de_out=1, and 0 otherwise. Repeat with PIPE=0.
- en toggling: drop en for 5 cycles mid-line. All outputs hold, and the line resumes with no lost or duplicated pixel.
- TICK_DIV=3: game_tick fires only on frames 1, 4, 7, … at v=4, h=0.
- nrst pulsed mid-hsync: hsync goes inactive on the next edge, and the restart matches the reset-release scenario.
